// File: rtl/matvec_seq.sv
// matvec_seq: matrix-vector sequencer, y = M*x, one row per dot product.
// Rows are fetched one at a time from an external memory with variable latency.
// Each row goes through an internal vec_mul, and every dot product is handed to a
// consumer that can apply backpressure.
// Optional feature macro: MATVEC_RELU_EN. When it is defined, negative dot results
// are clamped to zero before they are registered.
// Fixed point: signed two's complement, FIXPOINT_WIDTH bits, FIXPOINT_FRAC of them
// fractional. A multiply takes the full product, shifts it right arithmetically by
// FIXPOINT_FRAC and truncates it to FIXPOINT_WIDTH bits. An add wraps.

module vec_mul #(
   parameter int VEC_SIZE       = 16,
   parameter int FIXPOINT_WIDTH = 16,
   parameter int FIXPOINT_FRAC  = 8
) (
   input  logic [VEC_SIZE*FIXPOINT_WIDTH-1:0] i_a,
   input  logic [VEC_SIZE*FIXPOINT_WIDTH-1:0] i_b,
   output logic [FIXPOINT_WIDTH-1:0]          o_dot
);
   localparam int W  = FIXPOINT_WIDTH;
   localparam int PW = 2 * FIXPOINT_WIDTH;

   // Heap-ordered tree: leaves at VEC_SIZE..2*VEC_SIZE-1, node n sums 2n and 2n+1
   logic [W-1:0] node [1:2*VEC_SIZE-1];

   // Element products feed the leaves, then a pairwise reduction runs toward the root
   always_comb begin
      node = '{default: '0};
      for (int unsigned i = 0; i < VEC_SIZE; i++) begin
         node[VEC_SIZE + i] = W'((PW'($signed(i_a[i*W +: W])) *
                                  PW'($signed(i_b[i*W +: W]))) >>> FIXPOINT_FRAC);
      end
      for (int unsigned n = VEC_SIZE - 1; n >= 1; n--) begin
         node[n] = node[2*n] + node[2*n + 1];
      end
   end

   assign o_dot = node[1];

endmodule

module matvec_seq #(
   parameter int VEC_SIZE       = 16,
   parameter int ROWS           = 16,
   parameter int ROW_AW         = $clog2(ROWS),
   parameter int FIXPOINT_WIDTH = 16,
   parameter int FIXPOINT_FRAC  = 8
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_start,
   input  logic [ROW_AW:0]                    i_row_count,
   input  logic [VEC_SIZE*FIXPOINT_WIDTH-1:0] i_vec,
   output logic                               o_busy,
   output logic                               o_done,
   output logic                               o_row_req,
   output logic [ROW_AW-1:0]                  o_row_addr,
   input  logic                               i_row_valid,
   input  logic [VEC_SIZE*FIXPOINT_WIDTH-1:0] i_row_data,
   output logic                               o_res_valid,
   output logic [ROW_AW-1:0]                  o_res_idx,
   output logic [FIXPOINT_WIDTH-1:0]          o_res_data,
   input  logic                               i_res_ready
);
   localparam int              W        = FIXPOINT_WIDTH;
   localparam logic [ROW_AW:0] ROWS_MAX = (ROW_AW + 1)'(ROWS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_CALC,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [VEC_SIZE*W-1:0]   x_q, x_d;
   logic [VEC_SIZE*W-1:0]   row_q, row_d;
   logic [W-1:0]            res_q, res_d;
   logic [W-1:0]            dot_w;
   logic [ROW_AW-1:0]       idx_q, idx_d;
   logic [ROW_AW-1:0]       addr_q, addr_d;
   logic [ROW_AW:0]         cnt_q, cnt_d;
   logic [ROW_AW:0]         cnt_clamped;
   logic                    last_row;

   vec_mul #(
      .VEC_SIZE       (VEC_SIZE),
      .FIXPOINT_WIDTH (W),
      .FIXPOINT_FRAC  (FIXPOINT_FRAC)
   ) u_vec_mul (
      .i_a   (x_q),
      .i_b   (row_q),
      .o_dot (dot_w)
   );

   assign cnt_clamped = (i_row_count > ROWS_MAX) ? ROWS_MAX : i_row_count;
   assign last_row    = ({1'b0, idx_q} == (cnt_q - 1'b1));

   // Job sequencing: fetch a row, compute its dot product, hold it until accepted, advance
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      row_d   = row_q;
      res_d   = res_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               x_d   = i_vec;
               cnt_d = cnt_clamped;
               idx_d = '0;
               if (cnt_clamped == '0) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = '0;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (i_row_valid) begin
               row_d   = i_row_data;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
`ifdef MATVEC_RELU_EN
            res_d = dot_w[W-1] ? '0 : dot_w;
`else
            res_d = dot_w;
`endif
            state_d = S_EMIT;
         end
         S_EMIT: begin
            if (i_res_ready) begin
               if (last_row) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  addr_d  = idx_q + 1'b1;
                  state_d = S_REQ;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         row_q   <= '0;
         res_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         row_q   <= row_d;
         res_q   <= res_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_busy      = (state_q != S_IDLE);
   assign o_done      = (state_q == S_DONE);
   assign o_row_req   = (state_q == S_REQ);
   assign o_row_addr  = addr_q;
   assign o_res_valid = (state_q == S_EMIT);
   assign o_res_idx   = idx_q;
   assign o_res_data  = res_q;

endmodule

// File: tb/tb_matvec_seq.sv
// Testbench for matvec_seq: randomized jobs checked against a plain-arithmetic
// dot-product model. The bench also models the row memory and the consumer.
// Honours MATVEC_RELU_EN in the expected values.

module tb_matvec_seq;
   localparam int VS = 4;
   localparam int RW = 4;
   localparam int AW = 2;
   localparam int W  = 16;
   localparam int FR = 8;

   logic            clk = 1'b0;
   logic            rst, start, row_valid, res_ready;
   logic [AW:0]     row_count;
   logic [VS*W-1:0] vec, row_data;
   logic            busy, done, row_req, res_valid;
   logic [AW-1:0]   row_addr, res_idx_o;
   logic [W-1:0]    res_data_o;

   int errors = 0;
   int checks = 0;
   int unsigned cyc = 0;
   int base = 0;
   int mem_lat = 1;
   logic [VS*W-1:0] mem [RW];

   int           req_rel[$];
   int           req_addr[$];
   int           res_idx[$];
   logic [W-1:0] res_dat[$];
   int           done_rel[$];

   matvec_seq #(.VEC_SIZE(VS), .ROWS(RW), .FIXPOINT_WIDTH(W), .FIXPOINT_FRAC(FR)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_row_count(row_count), .i_vec(vec),
      .o_busy(busy), .o_done(done), .o_row_req(row_req), .o_row_addr(row_addr),
      .i_row_valid(row_valid), .i_row_data(row_data), .o_res_valid(res_valid),
      .o_res_idx(res_idx_o), .o_res_data(res_data_o), .i_res_ready(res_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [VS*W-1:0] mk(input logic [W-1:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   function automatic logic [VS*W-1:0] rnd_vec();
      logic [VS*W-1:0] v;
      for (int k = 0; k < VS; k++) v[k*W +: W] = W'($urandom);
      return v;
   endfunction

   // Reference: sum of (a*b)/2^FR floored, wrapped to W bits, optional ReLU
   function automatic logic [W-1:0] ref_dot(input logic [VS*W-1:0] row, input logic [VS*W-1:0] v);
      longint acc = 0;
      logic [W-1:0] r;
      for (int k = 0; k < VS; k++)
         acc += (longint'($signed(row[k*W +: W])) * longint'($signed(v[k*W +: W]))) >>> FR;
      r = acc[W-1:0];
`ifdef MATVEC_RELU_EN
      if (r[W-1]) r = '0;
`endif
      return r;
   endfunction

   // Event monitor, sampled mid-cycle
   initial forever begin
      @(negedge clk); #1;
      if (!rst) begin
         if (row_req) begin req_rel.push_back(int'(cyc) - base); req_addr.push_back(int'(row_addr)); end
         if (res_valid && res_ready) begin res_idx.push_back(int'(res_idx_o)); res_dat.push_back(res_data_o); end
         if (done) done_rel.push_back(int'(cyc) - base);
      end
   end

   // Row memory: answers each request mem_lat cycles later with a one-cycle valid
   initial begin
      row_valid = 1'b0;
      row_data  = '0;
      forever begin
         @(negedge clk);
         if (row_req) begin
            automatic int a = int'(row_addr);
            repeat (mem_lat) @(negedge clk);
            row_data  = mem[a];
            row_valid = 1'b1;
            @(negedge clk);
            row_valid = 1'b0;
            row_data  = rnd_vec();
         end
      end
   end

   task automatic start_job(input logic [AW:0] cnt, input logic [VS*W-1:0] v);
      @(negedge clk);
      req_rel.delete(); req_addr.delete(); res_idx.delete(); res_dat.delete(); done_rel.delete();
      base = int'(cyc);
      start = 1'b1; row_count = cnt; vec = v;
      @(negedge clk);
      start = 1'b0; row_count = AW'($urandom); vec = rnd_vec();
   endtask

   task automatic wait_done(input int budget, input bit rnd, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rnd) res_ready = 1'($urandom_range(0, 1));
         #2;
         if (done_rel.size() != 0) begin ok = 1'b1; break; end
      end
      res_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; row_count = '0; vec = '0; res_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, row_req, res_valid, row_addr, res_idx_o, res_data_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b req=%b valid=%b addr=%0d idx=%0d data=%h want all 0",
                  busy, done, row_req, res_valid, row_addr, res_idx_o, res_data_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [VS*W-1:0] x = mk(16'h0100, 16'h0200, 16'h0000, 16'h0000);
      logic [W-1:0] want [2] = '{16'h0180, 16'h0300};
      bit ok;
      mem[0] = mk(16'h0080, 16'h0080, 16'h0000, 16'h0000);
      mem[1] = mk(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      mem_lat = 1;
      start_job(3'd2, x);
      wait_done(200, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no done want done"); end
      checks++; if (res_idx.size() != 2) begin errors++; $display("FAIL basic_nres: got %0d want 2", res_idx.size()); end
      for (int i = 0; i < 2 && i < res_idx.size(); i++) begin
         checks++; if (res_idx[i] != i) begin errors++; $display("FAIL basic_idx%0d: got %0d want %0d", i, res_idx[i], i); end
         checks++; if (res_dat[i] !== want[i]) begin errors++; $display("FAIL basic_data%0d: got %h want %h", i, res_dat[i], want[i]); end
      end
      checks++;
      if (req_rel.size() != 2 || req_rel[0] != 1 || req_rel[1] != 5 || req_addr[0] != 0 || req_addr[1] != 1) begin
         errors++; $display("FAIL basic_req_timing: got n=%0d first=%0d want req at cycles 1,5 addr 0,1",
                            req_rel.size(), (req_rel.size() > 0) ? req_rel[0] : -1);
      end
      checks++; if (done_rel.size() != 1 || done_rel[0] != 9) begin errors++; $display("FAIL basic_done_cycle: got %0d want 9", (done_rel.size() > 0) ? done_rel[0] : -1); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got busy=%b done=%b want 0 0", busy, done); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] d0;
      logic [AW-1:0] i0;
      bit ok, seen;
      seen = 1'b0;
      res_ready = 1'b0;
      start_job(3'd2, mk(16'h0100, 16'h0200, 16'h0000, 16'h0000));
      for (int i = 0; i < 50; i++) begin @(negedge clk); if (res_valid) begin seen = 1'b1; break; end end
      checks++; if (!seen) begin errors++; $display("FAIL bp_valid_timeout: got no valid want valid"); end
      d0 = res_data_o; i0 = res_idx_o;
      checks++; if (d0 !== 16'h0180 || i0 !== 2'd0) begin errors++; $display("FAIL bp_first: got idx=%0d data=%h want 0 0180", i0, d0); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_data_o !== d0 || res_idx_o !== i0 || req_rel.size() != 1) begin
            errors++; $display("FAIL bp_hold%0d: got valid=%b idx=%0d data=%h reqs=%0d want 1 %0d %h 1",
                               i, res_valid, res_idx_o, res_data_o, req_rel.size(), i0, d0);
         end
      end
      res_ready = 1'b1;
      wait_done(200, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no done want done"); end
      checks++;
      if (res_dat.size() != 2 || res_dat[0] !== 16'h0180 || res_dat[1] !== 16'h0300 || res_idx[1] != 1) begin
         errors++; $display("FAIL bp_results: got n=%0d want (0,0180),(1,0300)", res_dat.size());
      end
      checks++; if (done_rel.size() != 1 || done_rel[0] != 14) begin errors++; $display("FAIL bp_done_cycle: got %0d want 14", (done_rel.size() > 0) ? done_rel[0] : -1); end
   endtask

   task automatic test_count_zero();
      bit ok;
      start_job(3'd0, rnd_vec());
      wait_done(50, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL zero_timeout: got no done want done"); end
      checks++;
      if (done_rel.size() != 1 || done_rel[0] != 1 || req_rel.size() != 0 || res_idx.size() != 0) begin
         errors++; $display("FAIL zero_job: got done=%0d reqs=%0d res=%0d want done@1 reqs=0 res=0",
                            (done_rel.size() > 0) ? done_rel[0] : -1, req_rel.size(), res_idx.size());
      end
   endtask

   task automatic test_clamp();
      logic [VS*W-1:0] x = rnd_vec();
      bit ok;
      for (int r = 0; r < RW; r++) mem[r] = rnd_vec();
      mem_lat = $urandom_range(1, 3);
      start_job(3'(RW + 3), x);
      wait_done(500, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL clamp_timeout: got no done want done"); end
      checks++; if (res_idx.size() != RW || req_rel.size() != RW) begin errors++; $display("FAIL clamp_nres: got res=%0d reqs=%0d want %0d", res_idx.size(), req_rel.size(), RW); end
      for (int i = 0; i < RW && i < res_idx.size(); i++) begin
         checks++;
         if (res_idx[i] != i || res_dat[i] !== ref_dot(mem[i], x)) begin
            errors++; $display("FAIL clamp_row%0d: got idx=%0d data=%h want %0d %h", i, res_idx[i], res_dat[i], i, ref_dot(mem[i], x));
         end
      end
      checks++; if (done_rel.size() != 1 || done_rel[0] != RW * (mem_lat + 3) + 1) begin errors++; $display("FAIL clamp_done_cycle: got %0d want %0d", (done_rel.size() > 0) ? done_rel[0] : -1, RW * (mem_lat + 3) + 1); end
   endtask

   task automatic test_negative();
      logic [W-1:0] want;
      bit ok;
`ifdef MATVEC_RELU_EN
      want = 16'h0000;
`else
      want = 16'hFE00;
`endif
      mem[0] = mk(16'hFE00, 16'h0000, 16'h0000, 16'h0000);
      mem_lat = 2;
      start_job(3'd1, mk(16'h0100, 16'h0100, 16'h0100, 16'h0100));
      wait_done(100, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL neg_timeout: got no done want done"); end
      checks++; if (res_dat.size() != 1 || res_dat[0] !== want) begin errors++; $display("FAIL neg_data: got n=%0d data=%h want %h", res_dat.size(), (res_dat.size() > 0) ? res_dat[0] : 16'hxxxx, want); end
   endtask

   task automatic test_reset_wait();
      bit ok, seen;
      seen = 1'b0;
      mem_lat = 4;
      start_job(3'd2, mk(16'h0100, 16'h0200, 16'h0000, 16'h0000));
      for (int i = 0; i < 20; i++) begin @(negedge clk); #2; if (req_rel.size() != 0) begin seen = 1'b1; break; end end
      checks++; if (!seen) begin errors++; $display("FAIL rstw_req_timeout: got no req want req"); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({busy, done, row_req, res_valid, row_addr, res_idx_o, res_data_o} !== '0) begin
            errors++; $display("FAIL rstw_idle%0d: got busy=%b done=%b req=%b valid=%b data=%h want all 0",
                               i, busy, done, row_req, res_valid, res_data_o);
         end
         @(negedge clk);
      end
      checks++; if (res_idx.size() != 0 || req_rel.size() != 1) begin errors++; $display("FAIL rstw_no_result: got res=%0d reqs=%0d want 0 1", res_idx.size(), req_rel.size()); end
      mem_lat = 1;
      start_job(3'd2, mk(16'h0100, 16'h0200, 16'h0000, 16'h0000));
      wait_done(200, 1'b0, ok);
      checks++;
      if (!ok || res_dat.size() != 2 || res_dat[0] !== ref_dot(mem[0], mk(16'h0100, 16'h0200, 16'h0000, 16'h0000)) ||
          res_dat[1] !== ref_dot(mem[1], mk(16'h0100, 16'h0200, 16'h0000, 16'h0000))) begin
         errors++; $display("FAIL rstw_next_job: got done=%b n=%0d want done with 2 correct results", ok, res_dat.size());
      end
   endtask

   task automatic test_start_ignored();
      logic [VS*W-1:0] x1 = rnd_vec();
      bit ok;
      for (int r = 0; r < RW; r++) mem[r] = rnd_vec();
      mem_lat = 2;
      start_job(3'd3, x1);
      repeat (3) @(negedge clk);
      start = 1'b1; vec = ~x1; row_count = 3'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done(300, 1'b0, ok);
      checks++; if (!ok || done_rel.size() != 1 || res_idx.size() != 3) begin errors++; $display("FAIL ign_shape: got done=%0d res=%0d want 1 3", done_rel.size(), res_idx.size()); end
      for (int i = 0; i < 3 && i < res_idx.size(); i++) begin
         checks++;
         if (res_dat[i] !== ref_dot(mem[i], x1)) begin errors++; $display("FAIL ign_row%0d: got %h want %h", i, res_dat[i], ref_dot(mem[i], x1)); end
      end
   endtask

   task automatic test_random();
      for (int j = 0; j < 6; j++) begin
         automatic logic [VS*W-1:0] x = rnd_vec();
         automatic logic [AW:0] cnt = 3'($urandom_range(0, 7));
         automatic int n = (cnt > RW) ? RW : int'(cnt);
         bit ok;
         for (int r = 0; r < RW; r++) mem[r] = rnd_vec();
         mem_lat = $urandom_range(1, 4);
         start_job(cnt, x);
         wait_done(2000, 1'b1, ok);
         checks++;
         if (!ok || done_rel.size() != 1 || res_idx.size() != n || req_rel.size() != n) begin
            errors++; $display("FAIL rnd%0d_shape: got done=%0d res=%0d reqs=%0d want 1 %0d %0d", j, done_rel.size(), res_idx.size(), req_rel.size(), n, n);
         end
         for (int i = 0; i < n && i < res_idx.size(); i++) begin
            checks++;
            if (res_idx[i] != i || res_dat[i] !== ref_dot(mem[i], x)) begin
               errors++; $display("FAIL rnd%0d_row%0d: got idx=%0d data=%h want %0d %h", j, i, res_idx[i], res_dat[i], i, ref_dot(mem[i], x));
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_count_zero();
      test_clamp();
      test_negative();
      test_reset_wait();
      test_start_ignored();
      test_random();
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
